// File: rtl/apb_uart_tx_if.sv
// apb_uart_tx_if: APB bus bundle between a master and the apb_uart_tx slave.
interface apb_uart_tx_if;
   logic       psel;
   logic [2:0] paddr;
   logic       penable;
   logic       pwrite;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pslverr;
   modport master(output psel, paddr, penable, pwrite, pwdata, input prdata, pslverr);
   modport slave(input psel, paddr, penable, pwrite, pwdata, output prdata, pslverr);
endinterface

// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB-configured UART transmitter with a one-entry holding buffer.
// Define APB_UART_TX_PARITY_EN to add PARITY_CR at address 5 and a parity bit per frame.
module apb_uart_tx (
   input  logic         clk,
   input  logic         n_rst,
   apb_uart_tx_if.slave apb,
   output logic         serial_out
);
`ifdef APB_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_en, par_odd, fpar_en, fpar_odd, par_acc;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t      state;
   logic [13:0] period, fperiod, timer;
   logic [3:0]  size, fsize, bit_cnt;
   logic [7:0]  buf_q, last_wr, shift, rdata;
   logic        buf_full, overrun, invalid, wr_en, tx_wr, err_clr, load, bit_end;
   always_comb begin
`ifdef APB_UART_TX_PARITY_EN
      invalid = apb.paddr == 3'd7;
`else
      invalid = apb.paddr[2] & apb.paddr[0];
`endif
      apb.pslverr = apb.psel & (invalid | (apb.pwrite & (apb.paddr[2:1] == 2'b00)));
      rdata = apb.paddr == 3'd0 ? {6'd0, buf_full, state != IDLE} :
              apb.paddr == 3'd1 ? {7'd0, overrun} :
              apb.paddr == 3'd2 ? period[7:0] :
              apb.paddr == 3'd3 ? {2'd0, period[13:8]} :
              apb.paddr == 3'd4 ? {4'd0, size} :
`ifdef APB_UART_TX_PARITY_EN
              apb.paddr == 3'd5 ? {6'd0, par_odd, par_en} :
`endif
              apb.paddr == 3'd6 ? last_wr : 8'h00;
      apb.prdata = (apb.psel & ~apb.pwrite) ? rdata : 8'h00;
      wr_en = apb.psel & apb.penable & apb.pwrite & ~apb.pslverr;
      tx_wr = wr_en & (apb.paddr == 3'd6);
      err_clr = apb.psel & apb.penable & ~apb.pwrite & (apb.paddr == 3'd1);
      load = (state == IDLE) & buf_full & (period >= 14'd2);
      bit_end = timer == fperiod - 14'd1;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         serial_out <= 1'b1;
         period <= '0;
         fperiod <= '0;
         timer <= '0;
         size <= '0;
         fsize <= '0;
         bit_cnt <= '0;
         buf_q <= '0;
         last_wr <= '0;
         shift <= '0;
         buf_full <= 1'b0;
         overrun <= 1'b0;
`ifdef APB_UART_TX_PARITY_EN
         par_en <= 1'b0;
         par_odd <= 1'b0;
         fpar_en <= 1'b0;
         fpar_odd <= 1'b0;
         par_acc <= 1'b0;
`endif
      end else begin
         if (wr_en && apb.paddr == 3'd2) period[7:0] <= apb.pwdata;
         if (wr_en && apb.paddr == 3'd3) period[13:8] <= apb.pwdata[5:0];
         if (wr_en && apb.paddr == 3'd4) size <= apb.pwdata[3:0];
`ifdef APB_UART_TX_PARITY_EN
         if (wr_en && apb.paddr == 3'd5) {par_odd, par_en} <= apb.pwdata[1:0];
`endif
         if (tx_wr) last_wr <= apb.pwdata;
         // A full buffer only accepts a new byte on the edge that empties it
         if (tx_wr && (!buf_full || load)) buf_q <= apb.pwdata;
         buf_full <= tx_wr | (buf_full & ~load);
         overrun <= (tx_wr & buf_full & ~load) | (overrun & ~err_clr);
         timer <= (state == IDLE || bit_end) ? 14'd0 : timer + 14'd1;
         case (state)
            IDLE: if (load) begin
               state <= START;
               serial_out <= 1'b0;
               shift <= buf_q;
               fperiod <= period;
               fsize <= (size >= 4'd5 && size <= 4'd8) ? size : 4'd8;
               bit_cnt <= '0;
`ifdef APB_UART_TX_PARITY_EN
               fpar_en <= par_en;
               fpar_odd <= par_odd;
               par_acc <= 1'b0;
`endif
            end
            START: if (bit_end) begin
               state <= DATA;
               serial_out <= shift[0];
            end
            DATA: if (bit_end) begin
               if (bit_cnt == fsize - 4'd1) begin
`ifdef APB_UART_TX_PARITY_EN
                  state <= fpar_en ? PARITY : STOP;
                  serial_out <= fpar_en ? (par_acc ^ shift[0] ^ fpar_odd) : 1'b1;
`else
                  state <= STOP;
                  serial_out <= 1'b1;
`endif
               end else begin
                  shift <= shift >> 1;
                  serial_out <= shift[1];
                  bit_cnt <= bit_cnt + 4'd1;
`ifdef APB_UART_TX_PARITY_EN
                  par_acc <= par_acc ^ shift[0];
`endif
               end
            end
`ifdef APB_UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
               state <= STOP;
               serial_out <= 1'b1;
            end
`endif
            STOP: if (bit_end) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: register table plus a serial-line scoreboard for apb_uart_tx.
module tb_apb_uart_tx;
   logic tb_clk = 1'b0;
   logic n_rst;
   logic serial_out;
   apb_uart_tx_if bus();
   apb_uart_tx dut(.clk(tb_clk), .n_rst(n_rst), .apb(bus.slave), .serial_out(serial_out));
   always #5 tb_clk = ~tb_clk;

   typedef struct {logic wr; logic [2:0] addr; logic [7:0] data; logic [7:0] exp; logic err;} vec_t;
   vec_t tbl[19];
   int checks = 0, passed = 0;
   logic [7:0] exp_q[$];
   time st_q[$];
   int mon_period = 10, mon_size = 8;
   logic mon_en = 1'b0, mon_busy = 1'b0;
   logic [7:0] mon_got;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] r, output logic e);
      @(negedge tb_clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
      @(negedge tb_clk);
      bus.penable = 1'b1;
      #1 r = bus.prdata; e = bus.pslverr;
      @(posedge tb_clk);
      #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      logic [7:0] r; logic e;
      apb(1'b1, a, d, r, e);
      check($sformatf("wr_err_a%0d", a), 32'(e), 32'd0);
   endtask

   task automatic rd_chk(input string n, input logic [2:0] a, input logic [7:0] x);
      logic [7:0] r; logic e;
      apb(1'b0, a, 8'h00, r, e);
      check(n, 32'({e, r}), 32'({1'b0, x}));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
         @(negedge tb_clk);
         n++;
      end
      check("drain_timeout", 32'(n < 3000), 32'd1);
      repeat (10) @(negedge tb_clk);
   endtask

   // Frame decoder: samples each bit mid-period and scores it against the queue
   initial forever begin
      @(negedge tb_clk);
      if (mon_en && serial_out === 1'b0) begin
         mon_busy = 1'b1;
         st_q.push_back($time);
         repeat (mon_period / 2 - 1) @(negedge tb_clk);
         check("start_bit", 32'(serial_out), 32'd0);
         mon_got = 8'h00;
         for (int i = 0; i < mon_size; i++) begin
            repeat (mon_period) @(negedge tb_clk);
            mon_got[i] = serial_out;
         end
         repeat (mon_period) @(negedge tb_clk);
         check("stop_bit", 32'(serial_out), 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_frame: got 0x%0h with empty queue", mon_got);
         end else check("frame_data", 32'(mon_got), 32'(exp_q.pop_front()));
         mon_busy = 1'b0;
      end
   end

   initial begin
      logic [7:0] b, r;
      logic e, hold;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
      n_rst = 1'b0;
      repeat (3) @(negedge tb_clk);
      check("reset_line", 32'(serial_out), 32'd1);
      n_rst = 1'b1;
      tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b0};
      tbl[5]  = '{1'b1, 3'd2, 8'h64, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 3'd3, 8'hC0, 8'h00, 1'b0};
      tbl[7]  = '{1'b0, 3'd2, 8'h00, 8'h64, 1'b0};
      tbl[8]  = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b0};
      tbl[9]  = '{1'b1, 3'd4, 8'h05, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 3'd4, 8'h00, 8'h05, 1'b0};
      tbl[11] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1};
      tbl[12] = '{1'b1, 3'd7, 8'hFF, 8'h00, 1'b1};
      tbl[13] = '{1'b1, 3'd0, 8'hFF, 8'h00, 1'b1};
      tbl[14] = '{1'b1, 3'd1, 8'hFF, 8'h00, 1'b1};
      tbl[15] = '{1'b0, 3'd2, 8'h00, 8'h64, 1'b0};
      tbl[16] = '{1'b0, 3'd4, 8'h00, 8'h05, 1'b0};
      tbl[17] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[18] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0};
      for (int i = 0; i < 19; i++) begin
         apb(tbl[i].wr, tbl[i].addr, tbl[i].data, r, e);
         check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].err));
         if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), 32'(r), 32'(tbl[i].exp));
      end
      check("line_idle", 32'(serial_out), 32'd1);

      // Exact frame shape: period 10, 8 data bits of 0xA5
      wr(3'd2, 8'd10); wr(3'd3, 8'd0); wr(3'd4, 8'd8);
      mon_period = 10; mon_size = 8; mon_en = 1'b1;
      b = 8'hA5;
      exp_q.push_back(b);
      wr(3'd6, b);
      @(negedge tb_clk);
      check("pre_start", 32'(serial_out), 32'd1);
      for (int c = 0; c < 100; c++) begin
         @(negedge tb_clk);
         check($sformatf("line_c%0d", c), 32'(serial_out),
               32'(c < 10 ? 1'b0 : c < 90 ? b[(c - 10) / 10] : 1'b1));
      end
      @(negedge tb_clk);
      check("post_idle", 32'(serial_out), 32'd1);
      drain();
      rd_chk("status_after", 3'd0, 8'h00);

      // Back-to-back frames, size 5, one idle clock between them
      wr(3'd4, 8'd5);
      mon_size = 5;
      st_q.delete();
      exp_q.push_back(8'h1D);
      wr(3'd6, 8'h1D);
      rd_chk("status_busy", 3'd0, 8'h01);
      exp_q.push_back(8'h03);
      wr(3'd6, 8'h03);
      rd_chk("status_busy_full", 3'd0, 8'h03);
      drain();
      check("frame_count", 32'(st_q.size()), 32'd2);
      if (st_q.size() >= 2) check("frame_gap", 32'(st_q[1] - st_q[0]), 32'd710);

      // Overrun: third byte is dropped while the buffer still holds the second
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h02);
      wr(3'd6, 8'h11);
      wr(3'd6, 8'h22);
      wr(3'd6, 8'h33);
      rd_chk("error_set", 3'd1, 8'h01);
      rd_chk("error_cleared", 3'd1, 8'h00);
      drain();

      // Period below 2 holds the byte; a period write releases it next edge
      wr(3'd2, 8'd0);
      exp_q.push_back(8'h15);
      wr(3'd6, 8'h55);
      hold = 1'b1;
      repeat (20) begin
         @(negedge tb_clk);
         hold = hold & serial_out;
      end
      check("hold_high", 32'(hold), 32'd1);
      rd_chk("status_full", 3'd0, 8'h02);
      wr(3'd2, 8'd10);
      @(negedge tb_clk);
      check("cfg_pre_start", 32'(serial_out), 32'd1);
      @(negedge tb_clk);
      check("cfg_start", 32'(serial_out), 32'd0);
      drain();

      // Asynchronous reset in the middle of a start bit
      mon_en = 1'b0;
      wr(3'd6, 8'h77);
      repeat (5) @(negedge tb_clk);
      check("mid_frame_low", 32'(serial_out), 32'd0);
      #1 n_rst = 1'b0;
      #1 check("reset_forces_high", 32'(serial_out), 32'd1);
      bus.psel = 1'b1; bus.paddr = 3'd0; bus.pwrite = 1'b0;
      #1 check("reset_status", 32'(bus.prdata), 32'd0);
      bus.psel = 1'b0;
      @(negedge tb_clk);
      n_rst = 1'b1;
      rd_chk("reset_period", 3'd2, 8'h00);
      repeat (30) @(negedge tb_clk);
      check("reset_buffer_gone", 32'(serial_out), 32'd1);
      rd_chk("reset_status_idle", 3'd0, 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/apb_uart_tx.md
Name: apb_uart_tx

Overview:
APB-slave-configured UART transmitter. It is the transmit-side counterpart of apb_uart_rx and shares its address map style, bit-period and data-size configuration, and 8-bit APB data path. Software writes a byte to TX_DATA. The block frames it as start, data (LSB first), then stop, and shifts it out on serial_out. A one-entry holding buffer allows back-to-back frames.

Parameters:
None. Widths are fixed: 3-bit paddr, 8-bit pwdata/prdata, 14-bit bit period, 4-bit data size.

Ports:
clk  in  1  system clock, rising-edge
n_rst  in  1  asynchronous active-low reset
psel  in  1  APB select
paddr  in  3  APB address
penable  in  1  APB access phase
pwrite  in  1  APB write (1) / read (0)
pwdata  in  8  APB write data
prdata  out  8  APB read data
pslverr  out  1  APB slave error
serial_out  out  1  UART line, idle high

Behaviour:
- Reset (async, n_rst=0):
  - serial_out=1; prdata=0; pslverr=0.
  - bit period=0, data size=0.
  - Buffer empty, error clear, FSM in IDLE.
  - Reset mid-frame forces serial_out high immediately and discards buffer and shift contents.
- Address map:
  - 0 STATUS (RO): bit0 tx_busy (FSM not IDLE), bit1 buf_full, other bits 0.
  - 1 ERROR (RO): bit0 overrun. Cleared on the edge completing a read of addr 1.
  - 2 BIT_CR0 (RW): period[7:0].
  - 3 BIT_CR1 (RW): period[13:8]. pwdata[7:6] are ignored and read back as 0.
  - 4 DATA_CR (RW): size[3:0]. Bits [7:4] are ignored and read back as 0.
  - 6 TX_DATA (RW): a write loads the buffer; a read returns the last byte written.
  - 5, 7: invalid.
- APB:
  - prdata and pslverr are combinational from paddr/pwrite whenever psel=1; both are 0 when psel=0.
  - pslverr=1 for any access to an invalid address, and for writes to addr 0 or 1.
  - A register write takes effect on the rising edge where psel & penable & pwrite and there is no error.
  - An errored write changes nothing.
- Buffer and overrun:
  - A TX_DATA write sets buf_full.
  - If the buffer is full and is not being transferred to the shift register on that same edge, the new byte is dropped, the old byte is kept, and overrun is set.
  - If the write and the transfer happen on the same edge, the write is accepted and buf_full stays 1.
  - If overrun set and an ERROR-read clear happen on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on an edge where buf_full=1 and the latched period ≥ 2.
    - On that edge: buffer → shift register, buf_full cleared, period and size latched into frame registers, bit counter cleared.
  - With period 0 or 1, the byte remains buffered and no frame starts.
  - Each bit is held for exactly the latched period in clocks, counted by a 14-bit timer.
  - START (serial_out=0) → DATA.
  - DATA: outputs shift[0]. It advances after each bit. After size bits it goes to STOP.
    - Size values 5..8 are used as-is; any other value is treated as 8.
  - STOP (serial_out=1) → IDLE.
- Latency and timing:
  - serial_out falls on the first rising edge after the TX_DATA write edge, when idle.
  - The gap between back-to-back frames is 1 clock, spent in IDLE.
  - Config writes during a frame affect only the next frame.

Optional Feature:
APB_UART_TX_PARITY_EN
- Defined:
  - Address 5 becomes PARITY_CR (RW): bit0 enable, bit1 odd (1) / even (0). Reset value 0.
  - When enabled, a PARITY state inserted between DATA and STOP outputs one parity bit over the size data bits, lasting one period.
- Undefined: address 5 stays invalid (pslverr=1) and there is no parity state.

Test Plan:
1. Reset, then read addresses 0, 1, 2, 3, 4 → all return 0x00; serial_out=1; pslverr=0.
2. Write BIT_CR0=0x64 and BIT_CR1=0xC0, then read both back → 0x64 and 0x00; write DATA_CR=0x05 → reads 0x05.
3. Read addr 7, write addr 7, write addr 0 → pslverr=1 on each; register contents unchanged.
4. Period=10, size=8, write 0xA5:
   - serial_out low 10 clocks, then 1,0,1,0,0,1,0,1 for 10 clocks each, then high 10 clocks.
   - STATUS reads 0x01 mid-frame and 0x00 after.
5. Period=10, size=5:
   - Write 0x1D, then 0x03 during its frame → two frames separated by 1 idle clock; data bits 1,0,1,1,1 then 1,1,0,0,0.
   - Then write 0x11, 0x22, 0x33 during one frame → 0x33 dropped; ERROR reads 0x01, then re-read gives 0x00.
6. Period=0: write 0x55 → serial_out stays high and STATUS=0x02. Then write period=10 → the frame starts on the following edge.
